// File: rtl/cp0_register_file_pkg.sv
// -----------------------------------------------------------------------------
// coprocessor0_params
//
// Purpose: shared definitions for the CP0 register file and its timer.
//   - CP0 register numbers (MFC0/MTC0 rd field)
//   - ExcCode values written into Cause.ExcCode
//   - Write masks for the software-writable Status/Cause fields
//   - WBToCP0Data: MTC0 request from writeback
//   - ExceptionCommitData: exception commit bundle from writeback
// -----------------------------------------------------------------------------
package coprocessor0_params;

  // CP0 register numbers
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  // Status: IM[7:0] (bits 15:8), EXL (bit 1), IE (bit 0). BEV (bit 22) is read-only.
  localparam logic [31:0] STATUS_WRITE_MASK = 32'h0000_FF03;
  localparam logic [31:0] STATUS_RESET      = 32'h0040_0000;
  localparam int          STATUS_BEV_BIT    = 22;
  localparam int          STATUS_EXL_BIT    = 1;
  localparam int          STATUS_IE_BIT     = 0;

  // Cause: only the software interrupt bits IP[1:0] (bits 9:8) are writable.
  localparam logic [31:0] CAUSE_WRITE_MASK = 32'h0000_0300;
  localparam int          CAUSE_BD_BIT     = 31;

  typedef struct packed {
    logic [4:0]  address;
    logic [2:0]  select;
    logic        enable;
    logic [31:0] data;
  } WBToCP0Data;

  typedef struct packed {
    logic        valid;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        in_delay_slot;
    logic        bad_vaddr_valid;
    logic [31:0] bad_vaddr;
  } ExceptionCommitData;

endpackage

// File: rtl/cp0_register_file_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
//
// Purpose: Count/Compare timer. A divider counts 0..COUNT_DIV-1 and Count
// increments on each divider wrap. TI is set (sticky) when the freshly
// incremented Count equals Compare; writing Compare clears TI.
//
// Ports:
//   clock, reset       core clock, asynchronous active-high reset
//   write_count_i      load Count from write_data_i (divider restarts)
//   write_compare_i    load Compare from write_data_i (clears TI)
//   write_data_i       MTC0 data
//   count_o            current Count
//   compare_o          current Compare
//   ti_o               timer interrupt flag
// -----------------------------------------------------------------------------
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_count_i,
  input  logic        write_compare_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic             ti_q, ti_d;
  logic             tick;

  always_comb begin
    tick      = (div_q == DIV_LAST);
    div_d     = div_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;

    if (write_count_i) begin
      // A Count load replaces this cycle's increment and restarts the divider.
      count_d = write_data_i;
      div_d   = '0;
    end else if (tick) begin
      div_d   = '0;
      count_d = count_q + 32'd1;
      if (count_d == compare_q) begin
        ti_d = 1'b1;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // The Compare write takes precedence over a match in the same cycle.
    if (write_compare_i) begin
      compare_d = write_data_i;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_register_file.sv
// -----------------------------------------------------------------------------
// cp0_register_file
//
// Purpose: coprocessor-0 register file and exception/interrupt controller.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC; takes MTC0 writes and
// exception/ERET commits from WB; drives the MFC0 read port, the interrupt
// request to ID and the redirect to IF.
//
// Build option: define CP0_TIMER_EN to implement Count/Compare/TI (cp0_timer).
// Without it Count and Compare read 0, writes to them are dropped and TI is 0.
//
// Ports:
//   clock, reset                 core clock, asynchronous active-high reset
//   wb_to_cp0                    MTC0 address/select/enable/data
//   read_register, read_select   MFC0 register/select
//   read_data                    MFC0 result (combinational, no bypass)
//   exception_*                  exception commit from WB
//   eret_valid                   ERET commit from WB
//   hardware_interrupt           level-sensitive interrupt lines
//   interrupt_pending            registered take-interrupt request
//   redirect_valid, redirect_pc  combinational flush/redirect to IF
// -----------------------------------------------------------------------------
module cp0_register_file
  import coprocessor0_params::*;
#(
  parameter int          HW_INT_COUNT  = 6,
  parameter int          COUNT_DIV     = 2,
  parameter logic [31:0] NORMAL_VECTOR = 32'h8000_0180,
  parameter logic [31:0] BOOT_VECTOR   = 32'hBFC0_0380
) (
  input  logic                    clock,
  input  logic                    reset,
  input  WBToCP0Data              wb_to_cp0,
  input  logic [4:0]              read_register,
  input  logic [2:0]              read_select,
  output logic [31:0]             read_data,
  input  logic                    exception_valid,
  input  logic [4:0]              exception_code,
  input  logic [31:0]             exception_pc,
  input  logic                    exception_in_delay_slot,
  input  logic                    exception_bad_vaddr_valid,
  input  logic [31:0]             exception_bad_vaddr,
  input  logic                    eret_valid,
  input  logic [HW_INT_COUNT-1:0] hardware_interrupt,
  output logic                    interrupt_pending,
  output logic                    redirect_valid,
  output logic [31:0]             redirect_pc
);

  ExceptionCommitData exc;
  assign exc = '{valid:           exception_valid,
                 code:            exception_code,
                 pc:              exception_pc,
                 in_delay_slot:   exception_in_delay_slot,
                 bad_vaddr_valid: exception_bad_vaddr_valid,
                 bad_vaddr:       exception_bad_vaddr};

  // Only non-timer architectural state lives here; the live IP[7:2]/TI bits
  // of Cause are overlaid at read time and never stored in cause_q.
  logic [31:0]             status_q, status_d;
  logic [31:0]             cause_q, cause_d;
  logic [31:0]             epc_q, epc_d;
  logic [31:0]             badvaddr_q, badvaddr_d;
  logic [HW_INT_COUNT-1:0] hw_q;
  logic                    pending_q, pending_d;

  logic [31:0] count_val, compare_val;
  logic        ti;
  logic        mtc0_fire, eret_fire;
  logic [5:0]  hw_ext;
  logic [31:0] cause_read;

  // Exception beats ERET beats MTC0; a losing request is dropped entirely.
  assign eret_fire = eret_valid & ~exc.valid;
  assign mtc0_fire = wb_to_cp0.enable & (wb_to_cp0.select == 3'd0)
                   & ~exc.valid & ~eret_valid;

`ifdef CP0_TIMER_EN
  cp0_timer #(
    .COUNT_DIV(COUNT_DIV)
  ) u_timer (
    .clock           (clock),
    .reset           (reset),
    .write_count_i   (mtc0_fire && (wb_to_cp0.address == CP0_COUNT)),
    .write_compare_i (mtc0_fire && (wb_to_cp0.address == CP0_COMPARE)),
    .write_data_i    (wb_to_cp0.data),
    .count_o         (count_val),
    .compare_o       (compare_val),
    .ti_o            (ti)
  );
`else
  assign count_val   = 32'd0;
  assign compare_val = 32'd0;
  assign ti          = 1'b0;
`endif

  // Unimplemented hardware lines read as 0.
  for (genvar gi = 0; gi < 6; gi++) begin : g_hw
    if (gi < HW_INT_COUNT) begin : g_used
      assign hw_ext[gi] = hw_q[gi];
    end else begin : g_unused
      assign hw_ext[gi] = 1'b0;
    end
  end

  // IP[7] is shared between hw line 5 and the timer interrupt.
  assign cause_read = cause_q | {1'b0, ti, 14'd0, hw_ext[5] | ti, hw_ext[4:0], 10'd0};

  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    // Evaluated on current state, so it drops one cycle after EXL sets.
    pending_d = (|(cause_read[15:8] & status_q[15:8]))
              & status_q[STATUS_IE_BIT] & ~status_q[STATUS_EXL_BIT];

    if (exc.valid) begin
      // Nested exception (EXL already set) keeps the original EPC/BD.
      if (!status_q[STATUS_EXL_BIT]) begin
        epc_d                 = exc.pc;
        cause_d[CAUSE_BD_BIT] = exc.in_delay_slot;
      end
      cause_d[6:2]             = exc.code;
      status_d[STATUS_EXL_BIT] = 1'b1;
      if (exc.bad_vaddr_valid) begin
        badvaddr_d = exc.bad_vaddr;
      end
    end else if (eret_fire) begin
      status_d[STATUS_EXL_BIT] = 1'b0;
    end else if (mtc0_fire) begin
      unique case (wb_to_cp0.address)
        CP0_STATUS: status_d = (status_q & ~STATUS_WRITE_MASK)
                             | (wb_to_cp0.data & STATUS_WRITE_MASK);
        CP0_CAUSE:  cause_d  = (cause_q & ~CAUSE_WRITE_MASK)
                             | (wb_to_cp0.data & CAUSE_WRITE_MASK);
        CP0_EPC:    epc_d    = wb_to_cp0.data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status_q   <= STATUS_RESET;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      hw_q       <= '0;
      pending_q  <= 1'b0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      hw_q       <= hardware_interrupt;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    read_data = 32'd0;
    if (read_select == 3'd0) begin
      unique case (read_register)
        CP0_BADVADDR: read_data = badvaddr_q;
        CP0_COUNT:    read_data = count_val;
        CP0_COMPARE:  read_data = compare_val;
        CP0_STATUS:   read_data = status_q;
        CP0_CAUSE:    read_data = cause_read;
        CP0_EPC:      read_data = epc_q;
        default:      read_data = 32'd0;
      endcase
    end
  end

  assign interrupt_pending = pending_q;
  assign redirect_valid    = ~reset & (exc.valid | eret_valid);
  assign redirect_pc       = exc.valid
                           ? (status_q[STATUS_BEV_BIT] ? BOOT_VECTOR : NORMAL_VECTOR)
                           : epc_q;

endmodule

// File: tb/tb_cp0_register_file.sv
// -----------------------------------------------------------------------------
// tb_cp0_register_file: directed vector table, hand-written sequences for
// interrupts, timer and reset, then randomized traffic against a reference
// model of the CP0 state.
// -----------------------------------------------------------------------------
module tb_cp0_register_file;
  import coprocessor0_params::*;

  localparam int          HW  = 6;
  localparam int          DIV = 2;
  localparam logic [31:0] NV  = 32'h8000_0180;
  localparam logic [31:0] BV  = 32'hBFC0_0380;

  logic        clock = 1'b0;
  logic        reset;
  WBToCP0Data  wb;
  logic [4:0]  rreg;
  logic [2:0]  rsel;
  logic [31:0] rdata;
  logic        exc_v, exc_bd, exc_bvv, eret;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_bv;
  logic [HW-1:0] hw;
  logic        pending, rv;
  logic [31:0] rpc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cp0_register_file #(
    .HW_INT_COUNT(HW), .COUNT_DIV(DIV), .NORMAL_VECTOR(NV), .BOOT_VECTOR(BV)
  ) dut (
    .clock(clock), .reset(reset), .wb_to_cp0(wb),
    .read_register(rreg), .read_select(rsel), .read_data(rdata),
    .exception_valid(exc_v), .exception_code(exc_code), .exception_pc(exc_pc),
    .exception_in_delay_slot(exc_bd), .exception_bad_vaddr_valid(exc_bvv),
    .exception_bad_vaddr(exc_bv), .eret_valid(eret), .hardware_interrupt(hw),
    .interrupt_pending(pending), .redirect_valid(rv), .redirect_pc(rpc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bev, m_bd, m_ti, m_pend;
  logic [4:0]  m_code;
  logic [1:0]  m_swip;
  logic [31:0] m_epc, m_badv, m_base, m_cmp;
  int unsigned m_ticks;
  logic [HW-1:0] m_hw;

  function automatic void model_reset();
    m_im = 0; m_exl = 0; m_ie = 0; m_bev = 1; m_bd = 0; m_ti = 0; m_pend = 0;
    m_code = 0; m_swip = 0; m_epc = 0; m_badv = 0; m_base = 0; m_cmp = 0;
    m_ticks = 0; m_hw = 0;
  endfunction

  // Count = value last loaded + whole divider periods since then.
  function automatic logic [31:0] model_count();
    return m_base + 32'(m_ticks / DIV);
  endfunction

  function automatic logic [7:0] model_ip();
    logic [7:0] ip;
    ip = {6'd0, m_swip};
    for (int i = 0; i < HW; i++) if (m_hw[i]) ip[2+i] = 1'b1;
    if (m_ti) ip[7] = 1'b1;
    return ip;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r, input logic [2:0] s);
    if (s != 0) return 32'd0;
    case (r)
      5'd8:  return m_badv;
`ifdef CP0_TIMER_EN
      5'd9:  return model_count();
      5'd11: return m_cmp;
`endif
      5'd12: return {9'd0, m_bev, 6'd0, m_im, 6'd0, m_exl, m_ie};
      5'd13: return {m_bd, m_ti, 14'd0, model_ip(), 1'b0, m_code, 2'b00};
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_step();
    logic new_pend;
    logic mt;
    new_pend = (|(model_ip() & m_im)) && m_ie && !m_exl;
    mt = wb.enable && (wb.select == 0) && !exc_v && !eret;
`ifdef CP0_TIMER_EN
    if (mt && wb.address == 5'd9) begin
      m_base = wb.data;
      m_ticks = 0;
    end else begin
      m_ticks++;
      if ((m_ticks % DIV) == 0 && model_count() == m_cmp) m_ti = 1;
    end
    if (mt && wb.address == 5'd11) begin
      m_cmp = wb.data;
      m_ti = 0;
    end
`endif
    if (exc_v) begin
      if (!m_exl) begin
        m_epc = exc_pc;
        m_bd = exc_bd;
      end
      m_code = exc_code;
      m_exl = 1;
      if (exc_bvv) m_badv = exc_bv;
    end else if (eret) begin
      m_exl = 0;
    end else if (mt) begin
      case (wb.address)
        5'd12: begin m_im = wb.data[15:8]; m_exl = wb.data[1]; m_ie = wb.data[0]; end
        5'd13: m_swip = wb.data[9:8];
        5'd14: m_epc = wb.data;
        default: ;
      endcase
    end
    m_hw = hw;
    m_pend = new_pend;
  endfunction

  // One clock: model advances with the DUT, then return to the falling edge.
  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    wb = '0; exc_v = 0; exc_code = 0; exc_pc = 0; exc_bd = 0; exc_bvv = 0;
    exc_bv = 0; eret = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wb = '{address: a, select: 3'd0, enable: 1'b1, data: d};
    step();
    wb = '0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] r, input logic [31:0] exp);
    rreg = r; rsel = 0;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic do_reset();
    reset = 1;
    #2;
    reset = 0;
    model_reset();
  endtask

  typedef struct {
    logic ev; logic [4:0] code; logic [31:0] pc; logic bd; logic bvv; logic [31:0] bv;
    logic er; logic mt; logic [4:0] maddr; logic [2:0] msel; logic [31:0] mdata;
    logic exp_rv; logic [31:0] exp_rpc; logic [4:0] rreg; logic [2:0] rsel; logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [4:0] addr_pool[8];
    clear_inputs();
    hw = 0; rreg = 0; rsel = 0; reset = 1;

    tbl[0]  = '{0,5'h00,32'h0,0,0,32'h0, 0,1,5'd12,3'd0,32'hFFFF_FFFF, 0,32'h0,        5'd12,3'd0,32'h0040_FF03};
    tbl[1]  = '{0,5'h00,32'h0,0,0,32'h0, 0,1,5'd12,3'd0,32'h0,         0,32'h0,        5'd12,3'd0,32'h0040_0000};
    tbl[2]  = '{1,5'h04,32'hBFC0_0100,1,1,32'h1234_5671, 0,0,5'd0,3'd0,32'h0, 1,32'hBFC0_0380, 5'd14,3'd0,32'hBFC0_0100};
    tbl[3]  = '{0,5'h00,32'h0,0,0,32'h0, 0,0,5'd0,3'd0,32'h0,          0,32'h0,        5'd13,3'd0,32'h8000_0010};
    tbl[4]  = '{0,5'h00,32'h0,0,0,32'h0, 0,0,5'd0,3'd0,32'h0,          0,32'h0,        5'd8, 3'd0,32'h1234_5671};
    tbl[5]  = '{0,5'h00,32'h0,0,0,32'h0, 0,0,5'd0,3'd0,32'h0,          0,32'h0,        5'd12,3'd0,32'h0040_0002};
    tbl[6]  = '{1,5'h0C,32'h8000_2000,0,0,32'h0, 0,0,5'd0,3'd0,32'h0,  1,32'hBFC0_0380, 5'd14,3'd0,32'hBFC0_0100};
    tbl[7]  = '{0,5'h00,32'h0,0,0,32'h0, 0,0,5'd0,3'd0,32'h0,          0,32'h0,        5'd13,3'd0,32'h8000_0030};
    tbl[8]  = '{0,5'h00,32'h0,0,0,32'h0, 0,0,5'd0,3'd0,32'h0,          0,32'h0,        5'd8, 3'd0,32'h1234_5671};
    tbl[9]  = '{0,5'h00,32'h0,0,0,32'h0, 1,0,5'd0,3'd0,32'h0,          1,32'hBFC0_0100, 5'd12,3'd0,32'h0040_0000};
    tbl[10] = '{1,5'h08,32'h8000_1000,0,0,32'h0, 1,0,5'd0,3'd0,32'h0,  1,32'hBFC0_0380, 5'd12,3'd0,32'h0040_0002};
    tbl[11] = '{0,5'h00,32'h0,0,0,32'h0, 0,0,5'd0,3'd0,32'h0,          0,32'h0,        5'd14,3'd0,32'h8000_1000};
    tbl[12] = '{1,5'h0A,32'h8000_3000,1,0,32'h0, 0,1,5'd14,3'd0,32'hDEAD_BEEF, 1,32'hBFC0_0380, 5'd14,3'd0,32'h8000_1000};
    tbl[13] = '{0,5'h00,32'h0,0,0,32'h0, 1,1,5'd12,3'd0,32'h0000_FF01, 1,32'h8000_1000, 5'd12,3'd0,32'h0040_0000};
    tbl[14] = '{0,5'h00,32'h0,0,0,32'h0, 0,1,5'd13,3'd0,32'hFFFF_FFFF, 0,32'h0,        5'd13,3'd0,32'h0000_0328};
    tbl[15] = '{0,5'h00,32'h0,0,0,32'h0, 0,1,5'd8, 3'd0,32'h0,         0,32'h0,        5'd8, 3'd0,32'h1234_5671};
    tbl[16] = '{0,5'h00,32'h0,0,0,32'h0, 0,1,5'd12,3'd1,32'hFFFF_FFFF, 0,32'h0,        5'd12,3'd0,32'h0040_0000};
    tbl[17] = '{0,5'h00,32'h0,0,0,32'h0, 0,0,5'd0,3'd0,32'h0,          0,32'h0,        5'd12,3'd1,32'h0000_0000};
    tbl[18] = '{0,5'h00,32'h0,0,0,32'h0, 0,0,5'd0,3'd0,32'h0,          0,32'h0,        5'd0, 3'd0,32'h0000_0000};

    // ---- reset state ----
    repeat (2) @(posedge clock);
    @(negedge clock);
    exc_v = 1;
    #1;
    chk("reset_redirect_valid", {31'd0, rv}, 32'd0);
    exc_v = 0;
    rd_chk("reset_status", 5'd12, 32'h0040_0000);
    rd_chk("reset_cause", 5'd13, 32'h0);
    rd_chk("reset_epc", 5'd14, 32'h0);
    rd_chk("reset_count", 5'd9, 32'h0);
    chk("reset_pending", {31'd0, pending}, 32'd0);
    model_reset();
    reset = 0;

    // ---- directed vector table ----
    for (int i = 0; i < 19; i++) begin
      clear_inputs();
      exc_v = tbl[i].ev; exc_code = tbl[i].code; exc_pc = tbl[i].pc; exc_bd = tbl[i].bd;
      exc_bvv = tbl[i].bvv; exc_bv = tbl[i].bv; eret = tbl[i].er;
      wb = '{address: tbl[i].maddr, select: tbl[i].msel, enable: tbl[i].mt, data: tbl[i].mdata};
      #1;
      chk($sformatf("vec%0d_redirect_valid", i), {31'd0, rv}, {31'd0, tbl[i].exp_rv});
      if (tbl[i].exp_rv) chk($sformatf("vec%0d_redirect_pc", i), rpc, tbl[i].exp_rpc);
      step();
      clear_inputs();
      rreg = tbl[i].rreg; rsel = tbl[i].rsel;
      #1;
      chk($sformatf("vec%0d_read", i), rdata, tbl[i].exp_rd);
    end

    // ---- reset asserted during an exception commit ----
    exc_v = 1; exc_code = EXC_SYS; exc_pc = 32'h8000_4000;
    #1;
    chk("midreset_rv_before", {31'd0, rv}, 32'd1);
    reset = 1;
    #1;
    chk("midreset_rv_during", {31'd0, rv}, 32'd0);
    rd_chk("midreset_status", 5'd12, 32'h0040_0000);
    rd_chk("midreset_epc", 5'd14, 32'h0);
    rd_chk("midreset_badvaddr", 5'd8, 32'h0);
    clear_inputs();
    reset = 0;
    model_reset();
    @(negedge clock);

    // ---- hardware interrupt line 0 ----
    mtc0(5'd12, 32'h0000_0401);
    hw = 6'b000001;
    step();
    rd_chk("hw_cause_ip2", 5'd13, 32'h0000_0400);
    chk("hw_pending_early", {31'd0, pending}, 32'd0);
    step();
    #1;
    chk("hw_pending_set", {31'd0, pending}, 32'd1);
    mtc0(5'd12, 32'h0000_0403);
    step();
    #1;
    chk("hw_pending_exl_drop", {31'd0, pending}, 32'd0);
    step();
    #1;
    chk("hw_pending_exl_hold", {31'd0, pending}, 32'd0);
    hw = 0;
    step();

    // ---- timer ----
    do_reset();
`ifdef CP0_TIMER_EN
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    repeat (9) step();
    rd_chk("timer_count4", 5'd9, 32'd4);
    rd_chk("timer_ti_clear", 5'd13, 32'h0);
    step();
    rd_chk("timer_count5", 5'd9, 32'd5);
    rd_chk("timer_ti_set", 5'd13, 32'h4000_8000);
    chk("timer_pending_early", {31'd0, pending}, 32'd0);
    step();
    #1;
    chk("timer_pending", {31'd0, pending}, 32'd1);
    mtc0(5'd11, 32'h100);
    rd_chk("timer_compare_clears_ti", 5'd13, 32'h0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd_chk("timer_load_max", 5'd9, 32'hFFFF_FFFF);
    step();
    rd_chk("timer_hold_div", 5'd9, 32'hFFFF_FFFF);
    step();
    rd_chk("timer_wrap", 5'd9, 32'h0);
`else
    mtc0(5'd9, 32'h100);
    rd_chk("notimer_count", 5'd9, 32'h0);
    mtc0(5'd11, 32'd5);
    rd_chk("notimer_compare", 5'd11, 32'h0);
    repeat (12) step();
    rd_chk("notimer_cause", 5'd13, 32'h0);
`endif

    // ---- randomized traffic against the model ----
    do_reset();
    addr_pool = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
    for (int n = 0; n < 3000; n++) begin
      clear_inputs();
      exc_v = ($urandom_range(0, 9) == 0);
      exc_code = 5'($urandom_range(0, 31));
      exc_pc = $urandom;
      exc_bd = 1'($urandom_range(0, 1));
      exc_bvv = 1'($urandom_range(0, 1));
      exc_bv = $urandom;
      eret = ($urandom_range(0, 9) == 0);
      wb.enable = ($urandom_range(0, 2) == 0);
      wb.address = addr_pool[$urandom_range(0, 7)];
      wb.select = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      wb.data = $urandom;
      if (wb.address == 5'd11) wb.data = model_count() + 32'($urandom_range(0, 6));
      if (wb.address == 5'd12 && $urandom_range(0, 1) == 1) wb.data[1] = 1'b0;
      if ($urandom_range(0, 7) == 0) hw = HW'($urandom);
      rreg = addr_pool[$urandom_range(0, 7)];
      rsel = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd0;
      #1;
      chk("rand_redirect_valid", {31'd0, rv}, {31'd0, exc_v | eret});
      if (exc_v) chk("rand_redirect_exc", rpc, m_bev ? BV : NV);
      else if (eret) chk("rand_redirect_eret", rpc, m_epc);
      chk($sformatf("rand_read_r%0d_s%0d", rreg, rsel), rdata, model_read(rreg, rsel));
      chk("rand_pending", {31'd0, pending}, {31'd0, m_pend});
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_register_file.md
Name: cp0_register_file

Overview:
- Parametrised coprocessor-0 register file and exception/interrupt controller for the MIPS core.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Accepts MTC0 writes from WB and exception/ERET commits from WB.
- Drives the combinational MFC0 read port, the interrupt-pending flag to ID, and the redirect PC to IF.

Parameters:
- HW_INT_COUNT, 6: number of implemented hardware interrupt lines (1..6); unused Cause.IP[7:2] bits read 0.
- COUNT_DIV, 2: core clocks per Count increment (≥1).
- NORMAL_VECTOR, 32'h8000_0180: exception target when Status.BEV=0.
- BOOT_VECTOR, 32'hBFC0_0380: exception target when Status.BEV=1.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- wb_to_cp0  in  WBToCP0Data  MTC0 address/select/enable/data
- read_register  in  5  MFC0 register number
- read_select  in  3  MFC0 select
- read_data  out  32  MFC0 result (combinational)
- exception_valid  in  1  WB commits an exception this cycle
- exception_code  in  5  ExcCode
- exception_pc  in  32  faulting instruction PC (branch PC if in slot)
- exception_in_delay_slot  in  1  BD flag
- exception_bad_vaddr_valid  in  1  load BadVAddr
- exception_bad_vaddr  in  32  faulting address
- eret_valid  in  1  WB commits ERET
- hardware_interrupt  in  HW_INT_COUNT  level interrupt lines
- interrupt_pending  out  1  take-interrupt request to ID
- redirect_valid  out  1  flush and redirect (combinational)
- redirect_pc  out  32  redirect target

Behaviour:
- Reset (async, active-high): Status = BEV=1, all other bits 0; Cause, EPC, Count, Compare, BadVAddr, divider all 0; interrupt_pending=0; redirect_valid=0.
- Read port: combinational, no bypass; an MTC0 in cycle N is visible in cycle N+1.
  - Unimplemented register or select≠0 reads 0.
- MTC0 writable fields:
  - Status: IM[7:0], EXL, IE only; BEV is read-only.
  - Cause: IP[1:0] only.
  - EPC: all 32 bits.
  - Count, Compare: all 32 bits.
  - BadVAddr: read-only.
  - Writes to unimplemented addresses are ignored.
- Priority in one cycle: exception > ERET > MTC0. A suppressed MTC0 or ERET has no effect.
- Exception commit:
  - If EXL=0: EPC←exception_pc, Cause.BD←exception_in_delay_slot.
  - If EXL=1: EPC and BD are unchanged.
  - Always: ExcCode←exception_code, EXL←1; BadVAddr←exception_bad_vaddr when its valid is set.
  - redirect_valid=1; redirect_pc = BEV ? BOOT_VECTOR : NORMAL_VECTOR.
- ERET: EXL←0; redirect_valid=1; redirect_pc=EPC (current value, pre-clock).
- Hardware interrupts: registered one cycle into Cause.IP[2+i].
  - Cause.IP[7] = registered hw[5] OR Cause.TI.
- interrupt_pending (registered) = |(Cause.IP & Status.IM) & IE & ~EXL.
  - Deasserts the cycle after EXL sets.
- Timer:
  - Divider counts 0..COUNT_DIV-1; Count increments on divider wrap; Count wraps 32'hFFFF_FFFF→0.
  - When the post-increment Count equals Compare, TI←1 (sticky).
  - MTC0 Compare clears TI; the write wins over a same-cycle match.
  - MTC0 Count loads the value and zeroes the divider; no increment that cycle.
- Reset asserted mid-exception: all state returns to reset values immediately; redirect_valid drops.

Optional Feature:
- CP0_TIMER_EN defined: Count/Compare/TI implemented as above.
- Undefined: Count and Compare read 0, writes ignored, TI constant 0, no divider logic.

Decomposition:
- Add to coprocessor0_params:
  - register-number constants CP0_BADVADDR=8, CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14;
  - ExcCode constants (INT=0x00, ADEL=0x04, ADES=0x05, SYS=0x08, BP=0x09, RI=0x0A, OV=0x0C);
  - an ExceptionCommitData struct bundling the exception_* inputs;
  - Status/Cause write-mask constants.
- Sub-module cp0_timer (divider, Count, Compare, TI), instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset → read Status = 32'h0040_0000; Cause, EPC, Count = 0; interrupt_pending=0.
- MTC0 Status=32'hFFFF_FFFF → readback 32'h0040_FF03.
- Exception, code 0x04, pc 32'hBFC0_0100, BD=1, BadVAddr 32'h1234_5671 →
  - redirect_pc 32'hBFC0_0380;
  - EPC 32'hBFC0_0100; Cause 32'h8000_0010; BadVAddr 32'h1234_5671; EXL=1.
- Second exception with EXL=1, pc 32'h8000_2000 → EPC unchanged; ExcCode updated.
- ERET → redirect_pc=EPC; EXL=0.
- Simultaneous ERET+exception → exception target; EXL stays 1.
- Timer (COUNT_DIV=2):
  - Compare=5, Count=0, IM[7]=1, IE=1 → Count reaches 5 after 10 cycles; TI=1; interrupt_pending=1 one cycle later.
  - MTC0 Compare clears TI.
  - Count=32'hFFFF_FFFF → wraps to 0.
- hardware_interrupt[0]=1 with IM[2]=1, IE=1 → Cause.IP[2]=1 next cycle; interrupt_pending the cycle after; with EXL=1, stays 0.
